// File: rtl/fb_rect_fill.sv
// fb_rect_fill: bus-mapped rectangle filler for a 1-bpp frame buffer.
// A processor programs two corners plus a colour, then strobes START.
// The block then writes one pixel per cycle in raster order to port A.
// Build option: define FB_FILL_IRQ_EN to add the IRQ output and IRQ_ACK input.
module fb_rect_fill #(
    parameter logic [7:0] BASE_ADDR = 8'hC0,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic        CLK,
    input  logic        RESET,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    output logic [14:0] FB_ADDR,
    output logic        FB_DATA,
    output logic        FB_WE,
`ifdef FB_FILL_IRQ_EN
    output logic        IRQ,
    input  logic        IRQ_ACK,
`endif
    output logic        BUSY
);

    localparam logic [7:0] XMAX_L = 8'(X_MAX);
    localparam logic [7:0] YMAX_L = 8'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    // Programmed corners: index 0 X0, 1 Y0, 2 X1, 3 Y1
    logic [7:0] r_coord [0:3];
    logic       r_colour;
    logic       r_done;

    // Working copy of the rectangle for the running fill
    logic [7:0] r_xmin;
    logic [7:0] r_xmax;
    logic [7:0] r_ymax;
    logic [7:0] r_col;
    logic [7:0] r_row;
    logic       r_fill_colour;

    // Read-back path
    logic       r_drive;
    logic [7:0] r_rd_data;

    logic [7:0] w_offset;
    logic       w_hit;
    logic       w_wr;
    logic       w_rd;
    logic       w_ctrl_wr;
    logic       w_abort;
    logic       w_start;
    logic       w_last;
    logic [7:0] w_xmin;
    logic [7:0] w_xmax;
    logic [7:0] w_ymin;
    logic [7:0] w_ymax;
    logic [7:0] w_rd_mux;

    // Address decode: offset wraps, so anything outside BASE..BASE+4 lands above 4
    always_comb begin
        w_offset  = BUS_ADDR - BASE_ADDR;
        w_hit     = (w_offset <= 8'd4);
        w_wr      = w_hit & BUS_WE;
        w_rd      = w_hit & ~BUS_WE;
        w_ctrl_wr = w_wr & (w_offset == 8'd4);
        w_abort   = w_ctrl_wr & BUS_DATA[2];
        // ABORT in the same write suppresses START
        w_start   = w_ctrl_wr & BUS_DATA[1] & ~BUS_DATA[2] & (r_state == S_IDLE);
        w_last    = (r_col == r_xmax) && (r_row == r_ymax);
    end

    // Normalise corners into min/max and clamp each to the visible area
    always_comb begin
        w_xmin = (r_coord[0] < r_coord[2]) ? r_coord[0] : r_coord[2];
        w_xmax = (r_coord[0] < r_coord[2]) ? r_coord[2] : r_coord[0];
        w_ymin = (r_coord[1] < r_coord[3]) ? r_coord[1] : r_coord[3];
        w_ymax = (r_coord[1] < r_coord[3]) ? r_coord[3] : r_coord[1];
        if (w_xmin > XMAX_L) w_xmin = XMAX_L;
        if (w_xmax > XMAX_L) w_xmax = XMAX_L;
        if (w_ymin > YMAX_L) w_ymin = YMAX_L;
        if (w_ymax > YMAX_L) w_ymax = YMAX_L;
    end

    // Next-state logic; ABORT overrides every other transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_next = S_FILL;
            S_FILL:  if (w_last)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) w_state_next = S_IDLE;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Programmable registers; coordinates are frozen while a fill is active
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) r_coord[i] <= 8'd0;
            r_colour <= 1'b0;
        end else begin
            if (w_wr && (r_state == S_IDLE) && (w_offset < 8'd4))
                r_coord[w_offset[1:0]] <= BUS_DATA;
            if (w_ctrl_wr)
                r_colour <= BUS_DATA[0];
        end
    end

    // Raster scan: column runs xmin..xmax, then wraps and the row advances
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_xmin        <= 8'd0;
            r_xmax        <= 8'd0;
            r_ymax        <= 8'd0;
            r_col         <= 8'd0;
            r_row         <= 8'd0;
            r_fill_colour <= 1'b0;
        end else if (w_start) begin
            r_xmin        <= w_xmin;
            r_xmax        <= w_xmax;
            r_ymax        <= w_ymax;
            r_col         <= w_xmin;
            r_row         <= w_ymin;
            r_fill_colour <= BUS_DATA[0];
        end else if ((r_state == S_FILL) && !w_abort && !w_last) begin
            if (r_col == r_xmax) begin
                r_col <= r_xmin;
                r_row <= r_row + 8'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    // Sticky DONE flag: completion wins over a same-cycle STATUS read
    always_ff @(posedge CLK) begin
        if (RESET)
            r_done <= 1'b0;
        else if (w_start)
            r_done <= 1'b0;
        else if ((r_state == S_DONE) && !w_abort)
            r_done <= 1'b1;
        else if (w_rd && (w_offset == 8'd4))
            r_done <= 1'b0;
    end

    // Read data selection
    always_comb begin
        w_rd_mux = 8'd0;
        if (w_offset == 8'd4)
            w_rd_mux = {6'd0, r_done, (r_state != S_IDLE)};
        else if (w_offset < 8'd4)
            w_rd_mux = r_coord[w_offset[1:0]];
    end

    // Bus drive is registered: on one cycle after a read hit, off one cycle after it ends
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_drive   <= 1'b0;
            r_rd_data <= 8'd0;
        end else begin
            r_drive   <= w_rd;
            r_rd_data <= w_rd_mux;
        end
    end

    assign BUS_DATA = r_drive ? r_rd_data : 8'bzzzz_zzzz;

    assign FB_ADDR = {r_row[6:0], r_col};
    assign FB_DATA = r_fill_colour;
    assign FB_WE   = (r_state == S_FILL);
    assign BUSY    = (r_state != S_IDLE);

`ifdef FB_FILL_IRQ_EN
    logic r_irq;

    // Completion interrupt; a new completion beats a same-cycle acknowledge
    always_ff @(posedge CLK) begin
        if (RESET)
            r_irq <= 1'b0;
        else if ((r_state == S_DONE) && !w_abort)
            r_irq <= 1'b1;
        else if (IRQ_ACK)
            r_irq <= 1'b0;
    end

    assign IRQ = r_irq;
`endif

endmodule

// File: tb/tb_fb_rect_fill.sv
// tb_fb_rect_fill: directed checks of the rectangle filler bus interface and scan.
module tb_fb_rect_fill;

    logic        clk;
    logic        reset;
    logic [7:0]  bus_addr;
    logic        bus_we;
    logic [7:0]  tb_drv;
    logic        tb_drv_en;
    wire  [7:0]  bus_data;
    logic [14:0] fb_addr;
    logic        fb_data;
    logic        fb_we;
    logic        busy;
`ifdef FB_FILL_IRQ_EN
    logic        irq;
    logic        irq_ack;
`endif

    int checks   = 0;
    int failures = 0;

    assign bus_data = tb_drv_en ? tb_drv : 8'bzzzz_zzzz;

    fb_rect_fill dut (
        .CLK      (clk),
        .RESET    (reset),
        .BUS_DATA (bus_data),
        .BUS_ADDR (bus_addr),
        .BUS_WE   (bus_we),
        .FB_ADDR  (fb_addr),
        .FB_DATA  (fb_data),
        .FB_WE    (fb_we),
`ifdef FB_FILL_IRQ_EN
        .IRQ      (irq),
        .IRQ_ACK  (irq_ack),
`endif
        .BUSY     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
        $display("check %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    // Caller is at a negedge; the write is sampled at the following posedge
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_we    = 1'b1;
        tb_drv    = d;
        tb_drv_en = 1'b1;
        @(negedge clk);
        bus_addr  = 8'h00;
        bus_we    = 1'b0;
        tb_drv_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr  = a;
        bus_we    = 1'b0;
        tb_drv_en = 1'b0;
        @(negedge clk);
        d         = bus_data;
        bus_addr  = 8'h00;
        @(negedge clk);
    endtask

    task automatic set_rect(input logic [7:0] x0, input logic [7:0] y0,
                            input logic [7:0] x1, input logic [7:0] y1);
        bus_write(8'hC0, x0);
        bus_write(8'hC1, y0);
        bus_write(8'hC2, x1);
        bus_write(8'hC3, y1);
    endtask

    // Called at the negedge right after the START write; first pixel is already out
    task automatic fill_check(input string tag, input int xmin, input int xmax,
                              input int ymin, input int ymax, input logic colour,
                              input logic inject);
        int k;
        logic [14:0] last_addr;
        k = 0;
        last_addr = 15'd0;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                last_addr = {y[6:0], x[7:0]};
                check($sformatf("%s_px%0d", tag, k), {15'd0, fb_we, fb_data, fb_addr},
                      {15'd0, 1'b1, colour, last_addr});
                if (inject) begin
                    if (k == 1) begin
                        bus_addr = 8'hC0; bus_we = 1'b1; tb_drv = 8'h00; tb_drv_en = 1'b1;
                    end else if (k == 2) begin
                        bus_addr = 8'hC4; bus_we = 1'b1; tb_drv = 8'h02; tb_drv_en = 1'b1;
                    end else if (k == 3) begin
                        bus_addr = 8'h00; bus_we = 1'b0; tb_drv_en = 1'b0;
                    end
                end
                k++;
                @(negedge clk);
            end
        end
        check({tag, "_done_state"}, {30'd0, fb_we, busy}, 32'd1);
        check({tag, "_addr_hold"}, {17'd0, fb_addr}, {17'd0, last_addr});
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, fb_we, busy}, 32'd0);
    endtask

    logic [7:0] rd;

    initial begin
        reset     = 1'b1;
        bus_addr  = 8'h00;
        bus_we    = 1'b0;
        tb_drv    = 8'h00;
        tb_drv_en = 1'b0;
`ifdef FB_FILL_IRQ_EN
        irq_ack   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_outs", {14'd0, fb_we, busy, fb_data, fb_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(8'hC0, rd); check("reset_x0", {24'd0, rd}, 32'h00);
        bus_read(8'hC4, rd); check("reset_status", {24'd0, rd}, 32'h00);

        // 3x2 rectangle, colour 1
        set_rect(8'd2, 8'd3, 8'd4, 8'd4);
        bus_read(8'hC2, rd); check("rd_x1", {24'd0, rd}, 32'h04);
        bus_read(8'hC1, rd); check("rd_y0", {24'd0, rd}, 32'h03);
        bus_write(8'hC4, 8'h03);
        fill_check("r1", 2, 4, 3, 4, 1'b1, 1'b0);
        bus_read(8'hC4, rd); check("r1_status", {24'd0, rd}, 32'h02);
        bus_read(8'hC4, rd); check("r1_status_clr", {24'd0, rd}, 32'h00);

        // Swapped X corners, colour 0
        set_rect(8'd10, 8'd0, 8'd5, 8'd0);
        bus_write(8'hC4, 8'h02);
        fill_check("swap", 5, 10, 0, 0, 1'b0, 1'b0);
        bus_read(8'hC4, rd); check("swap_status", {24'd0, rd}, 32'h02);

        // Clamped to the bottom-right corner
        set_rect(8'd158, 8'd118, 8'd200, 8'd200);
        bus_write(8'hC4, 8'h03);
        fill_check("clamp", 158, 159, 118, 119, 1'b1, 1'b0);
        bus_read(8'hC4, rd); check("clamp_status", {24'd0, rd}, 32'h02);

        // Single pixel
        set_rect(8'd7, 8'd9, 8'd7, 8'd9);
        bus_write(8'hC4, 8'h02);
        fill_check("single", 7, 7, 9, 9, 1'b0, 1'b0);
`ifdef FB_FILL_IRQ_EN
        check("irq_set", {31'd0, irq}, 32'd1);
        repeat (3) @(negedge clk);
        check("irq_hold", {31'd0, irq}, 32'd1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        check("irq_ack", {31'd0, irq}, 32'd0);
`endif
        bus_read(8'hC4, rd); check("single_status", {24'd0, rd}, 32'h02);

        // Register and START writes while busy are ignored
        set_rect(8'd2, 8'd1, 8'd5, 8'd2);
        bus_write(8'hC4, 8'h03);
        fill_check("busywr", 2, 5, 1, 2, 1'b1, 1'b1);
        bus_read(8'hC0, rd); check("busywr_x0", {24'd0, rd}, 32'h02);
        bus_read(8'hC4, rd); check("busywr_status", {24'd0, rd}, 32'h02);

        // Full-screen fill aborted after 50 pixels
        set_rect(8'd0, 8'd0, 8'd159, 8'd119);
        bus_write(8'hC4, 8'h03);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("abort_px%0d", i), {15'd0, fb_we, fb_data, fb_addr},
                  {15'd0, 1'b1, 1'b1, 7'd0, 8'(i)});
            if (i < 49) @(negedge clk);
        end
        bus_write(8'hC4, 8'h04);
        check("abort_stop", {30'd0, fb_we, busy}, 32'd0);
        @(negedge clk);
        check("abort_stay", {30'd0, fb_we, busy}, 32'd0);
        bus_read(8'hC4, rd); check("abort_status", {24'd0, rd}, 32'h00);

        // START and ABORT together: nothing starts
        bus_write(8'hC4, 8'h06);
        check("startabort", {30'd0, fb_we, busy}, 32'd0);
        @(negedge clk);
        check("startabort2", {30'd0, fb_we, busy}, 32'd0);

        // Reset in the middle of a fill
        set_rect(8'd1, 8'd1, 8'd20, 8'd20);
        bus_write(8'hC4, 8'h03);
        repeat (5) @(negedge clk);
        check("pre_reset_we", {31'd0, fb_we}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_outs", {14'd0, fb_we, busy, fb_data, fb_addr}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("postreset_we", {31'd0, fb_we}, 32'd0);
        bus_read(8'hC0, rd); check("rst_x0", {24'd0, rd}, 32'h00);
        bus_read(8'hC1, rd); check("rst_y0", {24'd0, rd}, 32'h00);
        bus_read(8'hC2, rd); check("rst_x1", {24'd0, rd}, 32'h00);
        bus_read(8'hC3, rd); check("rst_y1", {24'd0, rd}, 32'h00);
        bus_read(8'hC4, rd); check("rst_status", {24'd0, rd}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_rect_fill.md
FB_RECT_FILL -- requirements
Module: fb_rect_fill

Interface
REQ-001 Parameter BASE_ADDR, default 8'hC0, bus address of register 0; block decodes BASE_ADDR..BASE_ADDR+4.
REQ-002 Parameter X_MAX, default 159, largest legal pixel column.
REQ-003 Parameter Y_MAX, default 119, largest legal pixel row.
REQ-004 CLK  input  1  single clock; all state on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 BUS_DATA  inout  8  shared data bus; driven only during a read of this block, else high-Z.
REQ-007 BUS_ADDR  input  8  bus address.
REQ-008 BUS_WE  input  1  1 = processor write, 0 = read.
REQ-009 FB_ADDR  output  15  frame-buffer port-A address {row[6:0], col[7:0]}.
REQ-010 FB_DATA  output  1  pixel value to write.
REQ-011 FB_WE  output  1  frame-buffer port-A write enable, one pixel per cycle.
REQ-012 BUSY  output  1  high while a fill is in progress.

Function
REQ-013 Register map (offset from BASE_ADDR): 0 X0, 1 Y0, 2 X1, 3 Y1 (8 bits each); 4 CTRL on write, STATUS on read.
REQ-014 CTRL write bits: bit0 COLOUR, bit1 START (self-clearing strobe), bit2 ABORT (self-clearing strobe), bits7:3 ignored.
REQ-015 STATUS read = {6'b0, DONE, BUSY}; DONE is sticky, set on normal fill completion, cleared by a START accepted or by any read of STATUS.
REQ-016 Reads of offsets 0-3 return the stored value; BUS_DATA is driven in the cycle after the address matches with BUS_WE=0, released the cycle after the address leaves range.
REQ-017 Writes to offsets 0-3 while BUSY=1 are ignored; the stored value is unchanged.
REQ-018 On accepted START: working bounds = min/max of (X0,X1) and (Y0,Y1), each clamped to X_MAX/Y_MAX, latched together with COLOUR; later register writes do not affect the running fill.
REQ-019 FSM states IDLE, FILL, DONE; IDLE->FILL on accepted START; FILL->DONE after last pixel; DONE->IDLE unconditionally next cycle; any state->IDLE on ABORT.
REQ-020 START is accepted only in IDLE; START in FILL or DONE is ignored.
REQ-021 FILL scans in raster order: column increments from xmin to xmax, then column resets to xmin and row increments; ends after (xmax,ymax).
REQ-022 FB_WE=1 for every FILL cycle, FB_ADDR = current {row,col}, FB_DATA = latched colour; exactly (xmax-xmin+1)*(ymax-ymin+1) write cycles per fill.
REQ-023 First FB_WE cycle is the cycle immediately after the START write cycle; no idle cycles between pixels.
REQ-024 BUSY=1 in FILL and DONE, 0 in IDLE; DONE bit sets on the DONE->IDLE transition.
REQ-025 ABORT: FB_WE low from the next cycle, return to IDLE, DONE not set; START and ABORT in the same write: ABORT wins, no fill starts.
REQ-026 FB_WE=0 in IDLE and DONE; FB_ADDR/FB_DATA hold last value when FB_WE=0.
REQ-027 Single-pixel rectangle (X0=X1, Y0=Y1) produces exactly one write cycle.

Reset
REQ-028 RESET: FSM to IDLE, X0/Y0/X1/Y1/COLOUR/DONE=0, BUSY=0, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUS_DATA high-Z next cycle.
REQ-029 RESET during FILL terminates the fill with no further FB_WE cycles and no DONE indication.

Configuration
REQ-030 Macro FB_FILL_IRQ_EN defined: adds output IRQ (1 bit) and input IRQ_ACK (1 bit); IRQ sets on the DONE->IDLE transition, clears on IRQ_ACK=1 or RESET; set and ack in the same cycle leaves IRQ set.
REQ-031 FB_FILL_IRQ_EN undefined: IRQ and IRQ_ACK ports do not exist; all other behaviour identical.

Verification
REQ-032 Write X0=2,Y0=3,X1=4,Y1=4, CTRL=8'h03 -> 6 consecutive FB_WE cycles, addresses (2,3),(3,3),(4,3),(2,4),(3,4),(4,4), FB_DATA=1, then STATUS read=8'h02.
REQ-033 X0=10,X1=5,Y0=Y1=0, START -> cols 5..10 row 0, 6 writes; X1=200,Y1=200 with X0=Y0=158/118 -> clamped to 4 writes ending at (159,119).
REQ-034 Start 160x120 fill, ABORT after 50 writes -> exactly 50 FB_WE cycles, BUSY falls, STATUS=8'h00.
REQ-035 During a fill, write X0=0 and CTRL=8'h02 -> no effect on address sequence; readback of X0 unchanged.
REQ-036 Assert RESET mid-fill -> FB_WE=0 next cycle, all registers read 0, BUS_DATA high-Z when not addressed.
REQ-037 With FB_FILL_IRQ_EN: complete 1-pixel fill -> IRQ=1 after DONE, stays high until IRQ_ACK pulse, then 0.
